btn_debounce_pulse: RTL and testbench

//   Debounces one raw push-button and turns it into clean single-cycle events.

---
 rtl/btn_debounce_pulse.sv | 220 ++++++++++++++++++++++
 tb/tb_btn_debounce_pulse.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronises btn_raw, debounces it on slowclk sample ticks and emits
// a clean level plus press/release pulses; auto-repeat pulses exist only with BTN_REPEAT_EN defined.
`timescale 1ns/1ps
module btn_debounce_pulse #(
  parameter int unsigned STABLE_SAMPLES = 4,
  parameter int unsigned REPEAT_DELAY   = 16,
  parameter int unsigned REPEAT_PERIOD  = 4,
  parameter int unsigned CNT_W          = 5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic slowclk,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_SAMPLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      return value;
    end else begin
      return value + CNT_ONE;
    end
  endfunction

  logic                 btn_meta_r;
  logic                 btn_sync_r;
  logic                 slow_meta_r;
  logic                 slow_sync_r;
  logic                 slow_dly_r;
  logic                 tick_s;
  logic [CNT_W-1:0]     cnt_inc_s;
  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 level_r;
  logic                 press_r;
  logic                 release_r;

  // Two-flop synchronisers for the button and the divided clock, plus the strobe edge-detect flop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta_r  <= 1'b0;
      btn_sync_r  <= 1'b0;
      slow_meta_r <= 1'b0;
      slow_sync_r <= 1'b0;
      slow_dly_r  <= 1'b0;
    end else begin
      btn_meta_r  <= btn_raw;
      btn_sync_r  <= btn_meta_r;
      slow_meta_r <= slowclk;
      slow_sync_r <= slow_meta_r;
      slow_dly_r  <= slow_sync_r;
    end
  end

  // Sample strobe on each slowclk rising edge and the saturating debounce count increment
  always_comb begin
    tick_s    = slow_sync_r & ~slow_dly_r;
    cnt_inc_s = sat_inc(cnt_r);
  end

  // Debounce FSM; pulses are registered so they appear the cycle after the deciding tick
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      if (tick_s) begin
        case (state_r)
          IDLE: begin
            if (btn_sync_r) begin
              if (STABLE_C == CNT_ONE) begin
                state_r <= HELD;
                cnt_r   <= CNT_ZERO;
                level_r <= 1'b1;
                press_r <= 1'b1;
              end else begin
                state_r <= PRESS_CHK;
                cnt_r   <= CNT_ONE;
              end
            end else begin
              cnt_r <= CNT_ZERO;
            end
          end
          PRESS_CHK: begin
            if (btn_sync_r) begin
              if (cnt_inc_s == STABLE_C) begin
                state_r <= HELD;
                cnt_r   <= CNT_ZERO;
                level_r <= 1'b1;
                press_r <= 1'b1;
              end else begin
                cnt_r <= cnt_inc_s;
              end
            end else begin
              state_r <= IDLE;
              cnt_r   <= CNT_ZERO;
            end
          end
          HELD: begin
            if (!btn_sync_r) begin
              if (STABLE_C == CNT_ONE) begin
                state_r   <= IDLE;
                cnt_r     <= CNT_ZERO;
                level_r   <= 1'b0;
                release_r <= 1'b1;
              end else begin
                state_r <= REL_CHK;
                cnt_r   <= CNT_ONE;
              end
            end else begin
              cnt_r <= CNT_ZERO;
            end
          end
          REL_CHK: begin
            if (!btn_sync_r) begin
              if (cnt_inc_s == STABLE_C) begin
                state_r   <= IDLE;
                cnt_r     <= CNT_ZERO;
                level_r   <= 1'b0;
                release_r <= 1'b1;
              end else begin
                cnt_r <= cnt_inc_s;
              end
            end else begin
              state_r <= HELD;
              cnt_r   <= CNT_ZERO;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
        cnt_r   <= cnt_r;
      end
    end
  end

  assign btn_level     = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_RELOAD_C = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CNT_W-1:0] rep_cnt_r;
  logic [CNT_W-1:0] rep_inc_s;
  logic             repeat_r;

  // Saturating increment of the auto-repeat tick count
  always_comb begin
    rep_inc_s = sat_inc(rep_cnt_r);
  end

  // Auto-repeat: held outside HELD/REL_CHK at zero, counts stable HELD ticks, pauses in REL_CHK
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_r <= CNT_ZERO;
      repeat_r  <= 1'b0;
    end else begin
      repeat_r <= 1'b0;
      case (state_r)
        IDLE, PRESS_CHK: begin
          rep_cnt_r <= CNT_ZERO;
        end
        HELD: begin
          if (tick_s && btn_sync_r) begin
            if (rep_inc_s == REP_DELAY_C) begin
              rep_cnt_r <= REP_RELOAD_C;
              repeat_r  <= 1'b1;
            end else begin
              rep_cnt_r <= rep_inc_s;
            end
          end else begin
            rep_cnt_r <= rep_cnt_r;
          end
        end
        REL_CHK: begin
          rep_cnt_r <= rep_cnt_r;
        end
        default: begin
          rep_cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign repeat_pulse = repeat_r;
`else
  // Repeat timing parameters only matter when auto-repeat is built in
  logic unused_rep_cfg_s;
  assign unused_rep_cfg_s = (REPEAT_DELAY > REPEAT_PERIOD) ? 1'b1 : 1'b0;
  assign repeat_pulse     = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse: a run-length debounce model checks every cycle,
// and directed scenarios pin pulse counts and latencies with hand-computed values.
`timescale 1ns/1ps
module tb_btn_debounce_pulse;
  localparam int STABLE = 4;
  localparam int DELAY  = 16;
  localparam int PERIOD = 4;
`ifdef BTN_REPEAT_EN
  localparam int REP_EXP = 7;
`else
  localparam int REP_EXP = 0;
`endif

  logic clock;
  logic reset_n;
  logic slowclk;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  btn_debounce_pulse #(
    .STABLE_SAMPLES(STABLE),
    .REPEAT_DELAY  (DELAY),
    .REPEAT_PERIOD (PERIOD),
    .CNT_W         (5)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .slowclk      (slowclk),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // slowclk = clock/8, changed on falling edges; slow_freeze holds it at its current level
  logic       slow_freeze;
  logic [2:0] slow_div;
  initial begin
    slowclk  = 1'b0;
    slow_div = 3'd0;
    forever begin
      @(negedge clock);
      if (!slow_freeze) begin
        slow_div = slow_div + 3'd1;
        slowclk  = slow_div[2];
      end
    end
  end

  int n_tests, n_fail, cyc_n;
  int n_press, n_release, n_repeat;
  int last_press_cyc, last_release_cyc;

  // model: inputs seen through a two-cycle delay, ticks on strobe rises, and a level that
  // flips once STABLE consecutive tick samples disagree with it
  logic raw_d1, raw_d2, sl_d1, sl_d2, sl_d3;
  logic m_level;
  int   m_run, m_held;
  logic exp_level, exp_press, exp_release, exp_repeat;

  task automatic model_clear();
    raw_d1 = 1'b0; raw_d2 = 1'b0;
    sl_d1 = 1'b0; sl_d2 = 1'b0; sl_d3 = 1'b0;
    m_level = 1'b0; m_run = 0; m_held = 0;
  endtask

  task automatic model_update();
    logic samp, tk;
    exp_press = 1'b0; exp_release = 1'b0; exp_repeat = 1'b0;
    if (!reset_n) begin
      model_clear();
    end else begin
      samp = raw_d2;
      tk   = sl_d2 & ~sl_d3;
      if (tk) begin
        if (samp != m_level) begin
          m_run++;
          if (m_run >= STABLE) begin
            m_level = samp;
            m_run   = 0;
            m_held  = 0;
            if (samp) exp_press = 1'b1;
            else      exp_release = 1'b1;
          end
        end else begin
          if (m_level && m_run == 0) begin
            m_held++;
`ifdef BTN_REPEAT_EN
            if (m_held >= DELAY && ((m_held - DELAY) % PERIOD) == 0) exp_repeat = 1'b1;
`endif
          end
          m_run = 0;
        end
      end
      raw_d2 = raw_d1; raw_d1 = btn_raw;
      sl_d3 = sl_d2; sl_d2 = sl_d1; sl_d1 = slowclk;
    end
    exp_level = m_level;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_n, act, req);
    end
  endtask

  task automatic compare();
    chk("btn_level", int'(btn_level), int'(exp_level));
    chk("press_pulse", int'(press_pulse), int'(exp_press));
    chk("release_pulse", int'(release_pulse), int'(exp_release));
    chk("repeat_pulse", int'(repeat_pulse), int'(exp_repeat));
    if (press_pulse) begin n_press++; last_press_cyc = cyc_n; end
    if (release_pulse) begin n_release++; last_release_cyc = cyc_n; end
    if (repeat_pulse) n_repeat++;
  endtask

  task automatic step();
    @(posedge clock);
    cyc_n++;
    model_update();
    #1;
    compare();
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int p0, r0, q0, t0, lat;

  initial begin
    n_tests = 0; n_fail = 0; cyc_n = 0;
    n_press = 0; n_release = 0; n_repeat = 0;
    last_press_cyc = 0; last_release_cyc = 0;
    slow_freeze = 1'b0;
    btn_raw = 1'b0;
    reset_n = 1'b0;
    model_clear();
    exp_level = 1'b0; exp_press = 1'b0; exp_release = 1'b0; exp_repeat = 1'b0;
    @(negedge clock);
    run(3);
    chk("reset_level", int'(btn_level), 0);
    chk("reset_press", int'(press_pulse), 0);
    reset_n = 1'b1;
    run(20);

    // bounce: 2 ticks high, 2 low, 3 high, then low -> nothing accepted
    p0 = n_press; r0 = n_release;
    btn_raw = 1'b1; run(16);
    btn_raw = 1'b0; run(16);
    btn_raw = 1'b1; run(24);
    btn_raw = 1'b0; run(60);
    chk("bounce_presses", n_press - p0, 0);
    chk("bounce_releases", n_release - r0, 0);
    chk("bounce_level", int'(btn_level), 0);

    // clean press held 100 clocks
    p0 = n_press; r0 = n_release; t0 = cyc_n;
    btn_raw = 1'b1; run(100);
    lat = last_press_cyc - t0;
    chk("press_count", n_press - p0, 1);
    chk("press_latency_27_42", int'(lat >= 27 && lat <= 42), 1);
    chk("press_no_release", n_release - r0, 0);
    chk("press_level", int'(btn_level), 1);

    // release with a one-tick glitch high after two low ticks
    p0 = n_press; r0 = n_release;
    btn_raw = 1'b0; run(16);
    btn_raw = 1'b1; run(8);
    btn_raw = 1'b0; t0 = cyc_n; run(80);
    lat = last_release_cyc - t0;
    chk("release_count", n_release - r0, 1);
    chk("release_latency_27_42", int'(lat >= 27 && lat <= 42), 1);
    chk("release_no_press", n_press - p0, 0);
    chk("release_level", int'(btn_level), 0);

    // reset while held, released with the button still down
    btn_raw = 1'b1; run(60);
    chk("held_before_reset", int'(btn_level), 1);
    reset_n = 1'b0; run(3);
    chk("in_reset_level", int'(btn_level), 0);
    p0 = n_press; r0 = n_release;
    reset_n = 1'b1; run(60);
    chk("repress_count", n_press - p0, 1);
    chk("repress_no_release", n_release - r0, 0);
    chk("repress_level", int'(btn_level), 1);

    // stuck slowclk: toggling button must change nothing
    slow_freeze = 1'b1; run(4);
    p0 = n_press; r0 = n_release;
    for (int i = 0; i < 200; i++) begin
      if ((i % 3) == 0) btn_raw = ~btn_raw;
      step();
    end
    btn_raw = 1'b1; run(4);
    chk("stuck_presses", n_press - p0, 0);
    chk("stuck_releases", n_release - r0, 0);
    chk("stuck_level", int'(btn_level), 1);
    slow_freeze = 1'b0;

    // long hold: repeat pulses at held ticks 16..40 when auto-repeat is built in
    btn_raw = 1'b0; run(60);
    chk("pre_repeat_level", int'(btn_level), 0);
    p0 = n_press; r0 = n_release; q0 = n_repeat;
    btn_raw = 1'b1; run(368);
    btn_raw = 1'b0; run(60);
    chk("repeat_count", n_repeat - q0, REP_EXP);
    chk("repeat_presses", n_press - p0, 1);
    chk("repeat_releases", n_release - r0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
